// File: rtl/vga_text_pkg.sv
// Shared constants and FSM state type for the VGA text-mode line fetcher.
package vga_text_pkg;

  localparam int COLS  = 80;
  localparam int ROWS  = 60;
  localparam int VLAST = 524;

  localparam logic [7:0] SPACE_CHAR = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2,
    ST_READY = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/line_buffer_2x.sv
// Double-buffered character line store: the fetcher writes one bank while the
// display reads the other. Contents survive reset.
module line_buffer_2x #(
  parameter int COLS = vga_text_pkg::COLS
) (
  input  logic       clk,
  input  logic       wr_en_i,
  input  logic       wr_bank_i,
  input  logic [6:0] wr_addr_i,
  input  logic [7:0] wr_data_i,
  input  logic       rd_bank_i,
  input  logic [6:0] rd_addr_i,
  output logic [7:0] rd_data_o
);
  import vga_text_pkg::*;

  localparam logic [6:0] COLS_W = 7'(COLS);

  logic [7:0] bank0_q [COLS];
  logic [7:0] bank1_q [COLS];

  always_ff @(posedge clk) begin
    if (wr_en_i && (wr_addr_i < COLS_W)) begin
      if (wr_bank_i) begin
        bank1_q[wr_addr_i] <= wr_data_i;
      end else begin
        bank0_q[wr_addr_i] <= wr_data_i;
      end
    end
  end

  // Columns past the end of the row read as blank so the display margin is clean.
  always_comb begin
    rd_data_o = SPACE_CHAR;
    if (rd_addr_i < COLS_W) begin
      rd_data_o = rd_bank_i ? bank1_q[rd_addr_i] : bank0_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/vga_text_fetch_ctrl.sv
// Prefetches one text row per 8 scanlines from the shared data memory into the
// back line buffer and swaps buffers at the first scanline of each character row.
module vga_text_fetch_ctrl #(
  parameter int COLS  = vga_text_pkg::COLS,
  parameter int ROWS  = vga_text_pkg::ROWS,
  parameter int VLAST = vga_text_pkg::VLAST
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       line_start,
  input  logic [9:0]                 posy,
  input  logic                       cpu_req,
  input  logic                       cpu_we,
  input  logic [12:0]                cpu_addr,
  input  logic [7:0]                 cpu_wd,
  output logic                       cpu_gnt,
  output logic [7:0]                 cpu_rd,
  output logic                       cpu_rvalid,
  output logic [12:0]                mem_addr,
  output logic                       mem_we,
  output logic [7:0]                 mem_wd,
  input  logic [7:0]                 mem_rd,
  input  logic [6:0]                 disp_col,
  output logic [7:0]                 disp_char,
  output logic                       overrun,
  output vga_text_pkg::fetch_state_e dbg_state
);
  import vga_text_pkg::*;

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);

  fetch_state_e state_q;
  logic [6:0]   col_q;
  logic [12:0]  base_q;
  logic         front_q;
  logic         overrun_q;
  logic [6:0]   fill_col_q;
  logic         fill_we_q;
  logic         rvalid_q;

  logic [9:0]   posy_inc;
  logic [6:0]   tgt_row;
  logic         pref_hit;
  logic         prefetch_trig;
  logic         swap_trig;

  // Row after the last visible scanline is row 0 of the next frame.
  always_comb begin
    posy_inc      = posy + 10'd1;
    tgt_row       = (posy == 10'(VLAST)) ? 7'd0 : posy_inc[9:3];
    pref_hit      = ((posy[2:0] == 3'd7) && (posy < 10'd479)) || (posy == 10'(VLAST));
    prefetch_trig = line_start && pref_hit && (tgt_row < 7'(ROWS));
    swap_trig     = line_start && (posy[2:0] == 3'd0) && (posy < 10'd480);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      col_q      <= 7'd0;
      base_q     <= 13'd0;
      front_q    <= 1'b0;
      overrun_q  <= 1'b0;
      fill_col_q <= 7'd0;
      fill_we_q  <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      // Memory data lags the address by one cycle, so the write column lags too.
      fill_we_q  <= (state_q == ST_FETCH);
      fill_col_q <= col_q;
      rvalid_q   <= cpu_gnt && !cpu_we;

      if (swap_trig && (state_q != ST_READY)) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (prefetch_trig) begin
            state_q <= ST_FETCH;
            col_q   <= 7'd0;
            base_q  <= 13'(int'(tgt_row) * COLS);
          end
        end
        ST_FETCH: begin
          if (col_q == LAST_COL) begin
            state_q <= ST_FLUSH;
            col_q   <= 7'd0;
          end else begin
            col_q <= col_q + 7'd1;
          end
        end
        ST_FLUSH: begin
          state_q <= ST_READY;
        end
        ST_READY: begin
          if (swap_trig) begin
            front_q <= ~front_q;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // CPU port handshake: cpu_gnt is a same-cycle combinational answer to cpu_req;
  // a request is consumed only in a cycle where cpu_req && cpu_gnt, and a granted
  // read returns cpu_rd with cpu_rvalid high on the following cycle.
  always_comb begin
    cpu_gnt  = rst_n && cpu_req && (state_q != ST_FETCH);
    mem_addr = 13'd0;
    mem_we   = 1'b0;
    mem_wd   = 8'h00;
    if (state_q == ST_FETCH) begin
      mem_addr = base_q + 13'(col_q);
    end else if (cpu_gnt) begin
      mem_addr = cpu_addr;
      mem_we   = cpu_we;
      mem_wd   = cpu_wd;
    end
  end

  assign cpu_rd     = mem_rd;
  assign cpu_rvalid = rvalid_q;
  assign overrun    = overrun_q;
  assign dbg_state  = state_q;

  line_buffer_2x #(
    .COLS (COLS)
  ) u_line_buf (
    .clk       (clk),
    .wr_en_i   (fill_we_q),
    .wr_bank_i (~front_q),
    .wr_addr_i (fill_col_q),
    .wr_data_i (mem_rd),
    .rd_bank_i (front_q),
    .rd_addr_i (disp_col),
    .rd_data_o (disp_char)
  );

endmodule

// File: tb/tb_vga_text_fetch_ctrl.sv
// Bench for vga_text_fetch_ctrl: trigger table, directed row-fetch sequences and a
// randomized raster run checked against a row/bank-level reference model.
module tb_vga_text_fetch_ctrl;
  import vga_text_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  posy = 10'd0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [12:0] cpu_addr = 13'd0;
  logic [7:0]  cpu_wd = 8'h00;
  logic        cpu_gnt;
  logic [7:0]  cpu_rd;
  logic        cpu_rvalid;
  logic [12:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wd;
  logic [7:0]  mem_rd = 8'h00;
  logic [6:0]  disp_col = 7'd0;
  logic [7:0]  disp_char;
  logic        overrun;
  fetch_state_e dbg_state;

  vga_text_fetch_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_start (line_start),
    .posy       (posy),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wd     (cpu_wd),
    .cpu_gnt    (cpu_gnt),
    .cpu_rd     (cpu_rd),
    .cpu_rvalid (cpu_rvalid),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd),
    .disp_col   (disp_col),
    .disp_char  (disp_char),
    .overrun    (overrun),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / shared memory ----------------
  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int a);
    if (a >= 240 && a < 320) return 8'(8'h41 + (a - 240));
    return 8'(((a * 37) + 11) ^ (a >> 5));
  endfunction

  logic [7:0] mem_arr [8192];
  bit mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int a = 0; a < 8192; a++) mem_arr[a] <= init_val(a);
      mem_loaded <= 1'b1;
    end else begin
      mem_rd <= mem_arr[mem_addr];
      if (mem_we) mem_arr[mem_addr] <= mem_wd;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [8192];
  logic [7:0] bank_m [2][80];
  bit         bank_v [2];
  logic [7:0] snap [80];
  bit         sel_m, pend_m, ovr_m, rv_pend;
  int         k0, cyc;
  logic [7:0] exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic bit fetching_now();
    return pend_m && (cyc >= k0) && (cyc <= k0 + 79);
  endfunction

  task automatic check_outputs();
    bit exp_gnt;
    logic [7:0] d;
    exp_gnt = cpu_req && !fetching_now();
    chk("cpu_gnt", cpu_gnt, exp_gnt);
    if (fetching_now()) begin
      chk("fetch_addr", mem_addr, 13'(k0 == 0 ? 0 : 0) + 32'(snap_base + (cyc - k0)));
      chk("fetch_we", mem_we, 0);
    end else if (exp_gnt) begin
      chk("cpu_mem_addr", mem_addr, cpu_addr);
      chk("cpu_mem_we", mem_we, cpu_we);
      chk("cpu_mem_wd", mem_wd, cpu_wd);
    end else begin
      chk("idle_addr", mem_addr, 0);
      chk("idle_we", mem_we, 0);
    end
    chk("rvalid", cpu_rvalid, rv_pend);
    if (rv_pend && exp_q.size() > 0) begin
      d = exp_q.pop_front();
      chk("cpu_rd", cpu_rd, d);
    end
    chk("overrun", overrun, ovr_m);
    if (disp_col >= 7'd80) chk("disp_blank", disp_char, 8'h20);
    else if (bank_v[sel_m]) chk("disp_char", disp_char, bank_m[sel_m][disp_col]);
  endtask

  int snap_base;

  task automatic model_edge();
    bit gnt, is_swap, is_pref;
    int y, row;
    gnt = cpu_req && !fetching_now();
    if (gnt && cpu_we) ref_mem[cpu_addr] = cpu_wd;
    rv_pend = gnt && !cpu_we;
    if (rv_pend) exp_q.push_back(ref_mem[cpu_addr]);
    if (line_start) begin
      y = int'(posy);
      is_swap = (y % 8 == 0) && (y < 480);
      is_pref = ((y % 8 == 7) && (y < 479)) || (y == VLAST);
      if (is_swap) begin
        if (pend_m && cyc >= k0 + 81) begin
          for (int i = 0; i < 80; i++) bank_m[!sel_m][i] = snap[i];
          bank_v[!sel_m] = 1'b1;
          sel_m  = !sel_m;
          pend_m = 1'b0;
        end else begin
          ovr_m = 1'b1;
        end
      end
      if (is_pref && !pend_m) begin
        row = (y == VLAST) ? 0 : (y + 1) / 8;
        snap_base = row * 80;
        for (int i = 0; i < 80; i++) snap[i] = ref_mem[snap_base + i];
        bank_v[!sel_m] = 1'b0;
        pend_m = 1'b1;
        k0 = cyc + 1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic line(input int y);
    line_start = 1'b1;
    posy = 10'(y);
    step();
    line_start = 1'b0;
    posy = 10'($urandom_range(0, 1023));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    line_start = 1'b0;
    cpu_req = 1'b0;
    #1;
    chk("rst_rvalid", cpu_rvalid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    pend_m = 1'b0;
    sel_m = 1'b0;
    ovr_m = 1'b0;
    rv_pend = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    int posy;
    bit exp_fetch;
    bit exp_ovr;
  } trig_vec_t;

  trig_vec_t tv [12];

  initial begin
    int low_cnt;
    int y, gap;

    tv[0]  = '{7,   1'b1, 1'b0};
    tv[1]  = '{471, 1'b1, 1'b0};
    tv[2]  = '{479, 1'b0, 1'b0};
    tv[3]  = '{524, 1'b1, 1'b0};
    tv[4]  = '{0,   1'b0, 1'b1};
    tv[5]  = '{8,   1'b0, 1'b1};
    tv[6]  = '{472, 1'b0, 1'b1};
    tv[7]  = '{480, 1'b0, 1'b0};
    tv[8]  = '{23,  1'b1, 1'b0};
    tv[9]  = '{520, 1'b0, 1'b0};
    tv[10] = '{478, 1'b0, 1'b0};
    tv[11] = '{15,  1'b1, 1'b0};

    for (int a = 0; a < 8192; a++) ref_mem[a] = init_val(a);
    bank_v[0] = 1'b0;
    bank_v[1] = 1'b0;
    cyc = 0;
    k0 = 0;
    snap_base = 0;
    #1;
    do_reset();

    // Trigger decoding table.
    for (int i = 0; i < 12; i++) begin
      do_reset();
      line(tv[i].posy);
      chk($sformatf("tbl_fetch_%0d", tv[i].posy), dbg_state == ST_FETCH, tv[i].exp_fetch);
      chk($sformatf("tbl_ovr_%0d", tv[i].posy), overrun, tv[i].exp_ovr);
      idle(3);
    end

    // Row 3 fetch: 81 cycles to READY, then swap shows 'A' at column 0.
    do_reset();
    line(23);
    idle(80);
    chk("row3_flush", 32'(dbg_state), 32'(ST_FLUSH));
    idle(1);
    chk("row3_ready", 32'(dbg_state), 32'(ST_READY));
    idle(4);
    line(24);
    disp_col = 7'd0;
    #1;
    chk("row3_col0", disp_char, 8'h41);
    disp_col = 7'd100;
    #1;
    chk("col_oob_blank", disp_char, 8'h20);

    // CPU write into row 1 before it is fetched.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'd85; cpu_wd = 8'h5A;
    step();
    cpu_req = 1'b0; cpu_we = 1'b0;
    line(7);
    idle(85);
    line(8);
    disp_col = 7'd5;
    #1;
    chk("row1_col5", disp_char, 8'h5A);

    // posy 479 does not fetch; end of frame fetches row 0.
    line(479);
    chk("no_fetch_479", 32'(dbg_state), 32'(ST_IDLE));
    line(524);
    #1;
    chk("vlast_addr0", mem_addr, 0);
    idle(85);
    line(0);

    // CPU read held across a fetch.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'd333;
    line(15);
    low_cnt = 0;
    for (int i = 0; i < 120; i++) begin
      if (!cpu_gnt) low_cnt++;
      step();
    end
    chk("gnt_low_cycles", low_cnt, 80);
    cpu_req = 1'b0;
    idle(2);
    line(16);

    // Swap attempt mid-fetch sets overrun and leaves the front alone.
    line(31);
    idle(39);
    line(32);
    chk("ovr_mid_fetch", overrun, 1);
    chk("ovr_still_fetch", 32'(dbg_state), 32'(ST_FETCH));
    idle(45);
    line(40);
    chk("late_swap_idle", 32'(dbg_state), 32'(ST_IDLE));

    // Reset in the middle of a fetch, then a complete refetch.
    line(39);
    idle(30);
    do_reset();
    chk("post_rst_idle", 32'(dbg_state), 32'(ST_IDLE));
    idle(5);
    chk("post_rst_wait", 32'(dbg_state), 32'(ST_IDLE));
    line(39);
    idle(85);
    line(40);

    // Randomized raster with CPU traffic.
    y = $urandom_range(0, 524);
    for (int l = 0; l < 70; l++) begin
      gap = $urandom_range(15, 110);
      cpu_req = ($urandom_range(0, 3) == 0);
      cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = 13'($urandom_range(0, 8191));
      cpu_wd = 8'($urandom);
      line(y);
      for (int g = 0; g < gap; g++) begin
        cpu_req = ($urandom_range(0, 3) == 0);
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 13'($urandom_range(0, 8191));
        cpu_wd = 8'($urandom);
        disp_col = 7'($urandom_range(0, 127));
        step();
      end
      y = (y == 524) ? 0 : y + 1;
    end
    cpu_req = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
